// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush clears all.
// Also keeps a registered population count of the busy bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pending_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Issue is applied after writeback so the newer writer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_en && (wr_addr != AW'(REG_ZERO)))
            busy_nxt[wr_addr] = 1'b0;
        if (issue_en && (issue_rd != AW'(REG_ZERO)))
            busy_nxt[issue_rd] = 1'b1;
        if (flush)
            busy_nxt = '0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Integer register file with NUM_RD combinational read ports, one write port and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the writeback data/busy onto matching read ports.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_RD*AW-1:0]   rs_addr,
    output logic [NUM_RD*XLEN-1:0] rs_data,
    output logic [NUM_RD-1:0]      rs_busy,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   rf_wr_en,
    input  logic [AW-1:0]          rd_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   flush,
    output logic [AW:0]            pending_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_ok;

    assign wr_ok = rf_wr_en && (rd_addr != AW'(REG_ZERO));

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .wr_en       (rf_wr_en),
        .wr_addr     (rd_addr),
        .flush       (flush),
        .busy        (busy),
        .pending_cnt (pending_cnt)
    );

    // x0 is never written, so it reads as zero without a special case on the read side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (wr_ok) begin
            regs[rd_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic issue_hit;
    assign issue_hit = issue_en && (issue_rd == rd_addr);
`endif

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rs_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = wr_ok && (rd_addr == addr);
        assign rs_data[g*XLEN +: XLEN] = fwd ? wr_data : regs[addr];
        assign rs_busy[g]              = fwd ? issue_hit : busy[addr];
`else
        assign rs_data[g*XLEN +: XLEN] = regs[addr];
        assign rs_busy[g]              = busy[addr];
`endif
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb (NUM_RD=3): directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_register_file_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 3;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NUM_RD*AW-1:0]   rs_addr;
    logic [NUM_RD*XLEN-1:0] rs_data;
    logic [NUM_RD-1:0]      rs_busy;
    logic                   issue_en;
    logic [AW-1:0]          issue_rd;
    logic                   rf_wr_en;
    logic [AW-1:0]          rd_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   flush;
    logic [AW:0]            pending_cnt;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];

    register_file_sb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .rf_wr_en    (rf_wr_en),
        .rd_addr     (rd_addr),
        .wr_data     (wr_data),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] port_data(input int i);
        return rs_data[i*XLEN +: XLEN];
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < NREGS; r++)
            n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rf_wr_en && rd_addr != 0) begin
            m_regs[rd_addr] = wr_data;
            m_busy[rd_addr] = 1'b0;
        end
        if (issue_en && issue_rd != 0)
            m_busy[issue_rd] = 1'b1;
        if (flush)
            for (int r = 0; r < NREGS; r++)
                m_busy[r] = 1'b0;
    endtask

    // Expected same-cycle read result for an address given the current inputs.
    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (rf_wr_en && rd_addr != 0 && rd_addr == a)
            return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (rf_wr_en && rd_addr != 0 && rd_addr == a)
            return issue_en && (issue_rd == rd_addr);
`endif
        return m_busy[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_rd = '0;
        rf_wr_en = 1'b0; rd_addr  = '0; wr_data = '0;
        flush    = 1'b0;
    endtask

    task automatic set_rs(input int a0, input int a1, input int a2);
        rs_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic do_issue(input int r);
        idle(); issue_en = 1'b1; issue_rd = AW'(r); tick();
    endtask

    task automatic do_write(input int r, input logic [XLEN-1:0] d);
        idle(); rf_wr_en = 1'b1; rd_addr = AW'(r); wr_data = d; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XLEN-1:0] old_val;
        reset_n = 1'b0;
        idle();
        set_rs(5, 7, 0);
        model_reset();
        #12;
        check("reset_data0", port_data(0), 0);
        check("reset_busy", rs_busy, 0);
        check("reset_pending", pending_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset in the middle of activity.
        idle();
        rf_wr_en = 1'b1; rd_addr = 5; wr_data = 32'hDEADBEEF;
        issue_en = 1'b1; issue_rd = 7;
        tick();
        idle();
        #1;
        check("pre_rst_x5", port_data(0), 32'hDEADBEEF);
        check("pre_rst_busy_x7", rs_busy[1], 1);
        check("pre_rst_pending", pending_cnt, 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_x5", port_data(0), 0);
        check("rst_busy_x7", rs_busy[1], 0);
        check("rst_pending", pending_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // x0 protection.
        do_issue(0);
        do_write(0, 32'h12345678);
        idle();
        set_rs(0, 0, 0);
        #1;
        check("x0_data", port_data(0), 0);
        check("x0_busy", rs_busy, 0);
        check("x0_pending", pending_cnt, 0);

        // Scoreboard life cycle.
        do_issue(3);
        check("issue_x3_pending", pending_cnt, 1);
        do_issue(4);
        check("issue_x4_pending", pending_cnt, 2);
        idle();
        set_rs(3, 4, 0);
        #1;
        check("busy_x3", rs_busy[0], 1);
        check("busy_x4", rs_busy[1], 1);
        do_write(3, 32'hA5A5A5A5);
        idle();
        #1;
        check("wb_busy_x3", rs_busy[0], 0);
        check("wb_pending", pending_cnt, 1);
        check("wb_data_x3", port_data(0), 32'hA5A5A5A5);

        // Same-cycle issue and write to an already-busy register.
        do_write(4, 32'h0);
        do_issue(9);
        check("x9_issue_pending", pending_cnt, 1);
        idle();
        issue_en = 1'b1; issue_rd = 9;
        rf_wr_en = 1'b1; rd_addr = 9; wr_data = 32'h11;
        tick();
        idle();
        set_rs(9, 0, 0);
        #1;
        check("iw_data_x9", port_data(0), 32'h11);
        check("iw_busy_x9", rs_busy[0], 1);
        check("iw_pending", pending_cnt, 1);

        // Flush beats a simultaneous issue.
        do_write(9, 32'h22);
        for (int r = 1; r <= 6; r++)
            do_issue(r);
        check("flush_pre_pending", pending_cnt, 6);
        idle();
        flush = 1'b1; issue_en = 1'b1; issue_rd = 8;
        tick();
        idle();
        set_rs(8, 1, 6);
        #1;
        check("flush_busy", rs_busy, 0);
        check("flush_pending", pending_cnt, 0);

        // Read-during-write on all three ports.
        do_write(10, 32'h01020304);
        do_issue(10);
        idle();
        set_rs(10, 10, 10);
        rf_wr_en = 1'b1; rd_addr = 10; wr_data = 32'hCAFEF00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        old_val = 32'hCAFEF00D;
        for (int i = 0; i < NUM_RD; i++) begin
            check($sformatf("byp_data%0d", i), port_data(i), old_val);
            check($sformatf("byp_busy%0d", i), rs_busy[i], 0);
        end
`else
        old_val = 32'h01020304;
        for (int i = 0; i < NUM_RD; i++) begin
            check($sformatf("rdw_data%0d", i), port_data(i), old_val);
            check($sformatf("rdw_busy%0d", i), rs_busy[i], 1);
        end
`endif
        tick();
        idle();
        #1;
        for (int i = 0; i < NUM_RD; i++) begin
            check($sformatf("rdw_next_data%0d", i), port_data(i), 32'hCAFEF00D);
            check($sformatf("rdw_next_busy%0d", i), rs_busy[i], 0);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] a;
            @(negedge clk);
            issue_en = ($urandom_range(0, 2) != 0);
            issue_rd = AW'($urandom_range(0, NREGS - 1));
            rf_wr_en = ($urandom_range(0, 1) != 0);
            rd_addr  = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, NREGS - 1));
            wr_data  = $urandom;
            flush    = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NUM_RD; i++)
                rs_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? rd_addr
                                                                  : AW'($urandom_range(0, NREGS - 1));
            #1;
            for (int i = 0; i < NUM_RD; i++) begin
                a = rs_addr[i*AW +: AW];
                check($sformatf("rnd_data%0d_x%0d", i, a), port_data(i), exp_data(a));
                check($sformatf("rnd_busy%0d_x%0d", i, a), rs_busy[i], exp_busy(a));
            end
            tick();
            check("rnd_pending", pending_cnt, model_count());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
